// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, arbiter FSM states and the flag bundle.
// Codes match the result-mux select of the attached ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SLR = 4'd6;
  localparam logic [3:0] ALU_SAR = 4'd7;
  localparam logic [3:0] ALU_SC  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to ptr.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, round-robin.
// Operands are registered in front of the ALU and result/flags behind it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [3:0]   req_ctrl0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_ctrl1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_c
);

  arb_state_t   state_q, state_d;
  logic         rr_ptr_q;
  logic         owner_q;
  logic [N-1:0] op_a_q, op_b_q;
  logic [3:0]   op_ctrl_q;
  logic [N-1:0] res_q;
  alu_flags_t   flags_q;
  alu_flags_t   alu_flags;
  logic [1:0]   grant;
  logic         take;

  rr_arbiter2 u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign alu_flags = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};

  // rst_n gating keeps req_ready low while reset is held, even with valids asserted.
  assign take = (state_q == IDLE) && rst_n && (grant != 2'b00);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) req_ready = grant;
        if (take)  state_d   = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = owner_onehot(owner_q);
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand regs hold their last value outside EXEC so the ALU inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_ctrl_q <= '0;
      owner_q   <= 1'b0;
    end else if (take) begin
      owner_q   <= grant[1];
      op_a_q    <= grant[1] ? req_a1    : req_a0;
      op_b_q    <= grant[1] ? req_b1    : req_b0;
      op_ctrl_q <= grant[1] ? req_ctrl1 : req_ctrl0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      flags_q  <= '0;
      rr_ptr_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q    <= alu_result;
      flags_q  <= alu_flags;
      rr_ptr_q <= ~owner_q;
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_ctrl   = op_ctrl_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;

  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (req_ready == 2'b00));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run checked against a transaction-level arbitration model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned SH = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_ctrl0, req_ctrl1;
  logic [1:0]   rsp_valid, rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         busy;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_z, alu_n, alu_v, alu_c;

  alu_share_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_ctrl0  (req_ctrl0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_v      (alu_v),
    .alu_c      (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {n,z,c,v,result}; C on subtract means "no borrow".
  function automatic logic [N+3:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] op);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         c, v;
    wide = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[N-1:0]; c = wide[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        r = wide[N-1:0]; c = wide[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[SH-1:0];
      ALU_SLR: r = a >> b[SH-1:0];
      ALU_SAR: r = $signed(a) >>> b[SH-1:0];
      ALU_SC:  r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  always_comb {alu_n, alu_z, alu_c, alu_v, alu_result} = ref_alu(alu_a, alu_b, alu_ctrl);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, response due two cycles after
  // acceptance, tie broken by a pointer that flips to the other requester per op.
  int           m_cyc = 0;
  int           m_rsp_cyc = 0;
  bit           m_busy = 1'b0;
  bit           m_ptr = 1'b0;
  bit           m_owner = 1'b0;
  logic [N-1:0] m_a, m_b, m_res;
  logic [3:0]   m_ctrl, m_flg;
  logic [1:0]   m_rdy, m_rv;

  always @(negedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", rsp_flags, 0);
      chk("rst_alu_ops", {alu_ctrl, alu_a, alu_b}, 0);
    end else begin
      m_rdy = 2'b00;
      if (!m_busy) m_rdy = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
      m_rv = (m_busy && m_cyc >= m_rsp_cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("m_req_ready", req_ready, m_rdy);
      chk("m_rsp_valid", rsp_valid, m_rv);
      chk("m_busy", busy, m_busy);
      if (m_busy && m_cyc == m_rsp_cyc - 1)
        chk("m_alu_inputs", {alu_ctrl, alu_a, alu_b}, {m_ctrl, m_a, m_b});
      if (m_rv != 2'b00) begin
        chk("m_rsp_result", rsp_result, m_res);
        chk("m_rsp_flags", rsp_flags, m_flg);
        if (rsp_ready[m_owner]) m_busy = 1'b0;
      end else if (m_rdy != 2'b00) begin
        m_busy    = 1'b1;
        m_owner   = m_rdy[1];
        m_ptr     = !m_owner;
        m_rsp_cyc = m_cyc + 2;
        m_a       = m_owner ? req_a1 : req_a0;
        m_b       = m_owner ? req_b1 : req_b0;
        m_ctrl    = m_owner ? req_ctrl1 : req_ctrl0;
        {m_flg, m_res} = ref_alu(m_a, m_b, m_ctrl);
      end
    end
  end

  task automatic set_req(input bit r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] c);
    if (r) begin req_a1 = a; req_b1 = b; req_ctrl1 = c; end
    else   begin req_a0 = a; req_b0 = b; req_ctrl0 = c; end
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_accept(input bit r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) ok = 1'b1;
    end
    chk("accept_within_bound", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (!busy && rsp_valid == 2'b00) ok = 1'b1;
    end
    chk("idle_within_bound", ok, 1);
  endtask

  function automatic logic [N-1:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  typedef struct {
    bit           req;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
    logic [N-1:0] res;
    logic [3:0]   flg;
    int unsigned  stall;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    logic [1:0] own, other_rdy;
    own       = v.req ? 2'b10 : 2'b01;
    other_rdy = ~own;
    @(posedge clk); #1;
    rsp_ready = (v.stall != 0) ? 2'b00 : 2'b11;
    set_req(v.req, v.a, v.b, v.ctrl);
    wait_accept(v.req);
    @(posedge clk); #1;
    req_valid = '0;
    if (v.stall != 0) set_req(!v.req, 32'h1, 32'h2, ALU_ADD);
    @(negedge clk);
    chk("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("vec_rsp_valid", rsp_valid, own);
    chk("vec_result", rsp_result, v.res);
    chk("vec_flags", rsp_flags, v.flg);
    if (v.stall != 0) begin
      for (int unsigned k = 0; k < v.stall; k++) begin
        @(posedge clk); #1;
        rsp_ready = k[0] ? other_rdy : 2'b00;
        @(negedge clk);
        chk("stall_rsp_valid", rsp_valid, own);
        chk("stall_result", rsp_result, v.res);
        chk("stall_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = own;
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 2'b11;
      chk("stall_released", rsp_valid, 0);
    end else begin
      @(posedge clk); #1;
      chk("released", rsp_valid, 0);
    end
  endtask

  logic [1:0] hs, prev, expg;
  int         n_ops, n0, last;

  initial begin
    vecs[0]  = '{1'b0, 32'd5,         32'd7,         ALU_ADD, 32'd12,        4'b0000, 0};
    vecs[1]  = '{1'b0, 32'd3,         32'd3,         ALU_SUB, 32'd0,         4'b0110, 0};
    vecs[2]  = '{1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 4'b1000, 5};
    vecs[3]  = '{1'b0, 32'h7FFF_FFFF, 32'd1,         ALU_ADD, 32'h8000_0000, 4'b1001, 0};
    vecs[4]  = '{1'b1, 32'd0,         32'd1,         ALU_SUB, 32'hFFFF_FFFF, 4'b1000, 0};
    vecs[5]  = '{1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, ALU_XOR, 32'hFFFF_FFFF, 4'b1000, 0};
    vecs[6]  = '{1'b0, 32'd1,         32'd31,        ALU_SLL, 32'h8000_0000, 4'b1000, 0};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'd4,         ALU_SAR, 32'hF800_0000, 4'b1000, 0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd4,         ALU_SLR, 32'h0800_0000, 4'b0000, 0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         ALU_SC,  32'd1,         4'b0000, 0};
    vecs[10] = '{1'b1, 32'd0,         32'd0,         ALU_OR,  32'd0,         4'b0100, 0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         ALU_ADD, 32'd0,         4'b0110, 0};

    // Reset held with both requesters asking.
    rst_n = 1'b0;
    rsp_ready = 2'b11;
    req_valid = '0;
    set_req(1'b0, 32'd5, 32'd7, ALU_ADD);
    set_req(1'b1, 32'd9, 32'd4, ALU_SUB);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_req0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    foreach (vecs[i]) run_vec(vecs[i]);
    wait_idle();

    // Both requesters continuously valid: strict alternation, one op per 3 cycles.
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    set_req(1'b0, 32'd10, 32'd20, ALU_ADD);
    set_req(1'b1, 32'd50, 32'd8, ALU_SUB);
    n_ops = 0; n0 = 0; last = 0; prev = 2'b00;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        if (n_ops > 0) begin
          expg = ~prev;
          chk("alt_grant", hs, expg);
          chk("alt_spacing", c - last, 3);
        end
        prev = hs; last = c; n_ops++;
        if (hs[0]) n0++;
      end
    end
    chk("alt_op_count", n_ops, 20);
    chk("alt_req0_share", n0, 10);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset during EXEC.
    @(posedge clk); #1;
    set_req(1'b0, 32'd1, 32'd2, ALU_ADD);
    wait_accept(1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1 chk("exec_rst_busy", busy, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("exec_rst_no_stale", rsp_valid, 0);
    end

    // Reset during RESP with the response stalled.
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    set_req(1'b1, 32'd6, 32'd9, ALU_OR);
    wait_accept(1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("resp_before_rst", rsp_valid, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("resp_rst_drop", rsp_valid, 0);
    chk("resp_rst_result", rsp_result, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("resp_rst_no_stale", rsp_valid, 0);
    end

    // Randomized traffic; the model checks every cycle.
    hs = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i[0], rand_opnd(), rand_opnd(), 4'($urandom_range(0, 8)));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      hs = req_valid & req_ready;
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 2'b11;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
